// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, issues word reads to a synchronous
// ROM with one cycle of read latency, and offers each fetched word to decode
// over a valid/ready handshake. Execute can redirect the PC at any time, and
// fetch parks in HALT once the PC leaves the populated part of the ROM.
module fetch_sequencer #(
    parameter int               PC_W      = 32,
    parameter int               ROM_DEPTH = 16,
    parameter logic [PC_W-1:0]  RESET_PC  = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    output logic [PC_W-1:0] rom_index,
    input  logic [31:0]     rom_data,
    output logic [31:0]     instr,
    output logic [PC_W-1:0] instr_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            halted,
    output logic [15:0]     fetch_cnt
);

    // IDLE: parked, REQ: address presented, WAIT: ROM data arriving,
    // HOLD: word offered to decode, HALT: PC outside the ROM.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3,
        HALT = 3'd4
    } state_t;

    localparam logic [PC_W-1:0] DEPTH_PC = PC_W'(ROM_DEPTH);
    localparam logic [PC_W-1:0] PC_ONE   = PC_W'(1);

    state_t          state;
    logic [PC_W-1:0] pc;
    logic            transfer;
    logic            pc_outside;
    logic            redirect_outside;

    // The ROM address always follows the PC; the ROM itself registers it.
    assign rom_index        = pc;
    assign transfer         = instr_valid & instr_ready;
    assign pc_outside       = (pc >= DEPTH_PC);
    assign redirect_outside = (redirect_pc >= DEPTH_PC);

    // Sequencer state, PC and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            fetch_cnt   <= '0;
            halted      <= 1'b0;
        end else begin
            // A handshake completing in HOLD always counts, even when a
            // redirect lands in the same cycle.
            if (state == HOLD && transfer && fetch_cnt != 16'hFFFF) begin
                fetch_cnt <= fetch_cnt + 16'd1;
            end

            if (redirect_valid) begin
                // Redirect wins over everything; a word still in the ROM
                // pipeline is simply never captured.
                pc          <= redirect_pc;
                instr_valid <= 1'b0;
                if (redirect_outside) begin
                    state  <= HALT;
                    halted <= 1'b1;
                end else begin
                    state  <= en ? REQ : IDLE;
                    halted <= 1'b0;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (en) begin
                            if (pc_outside) begin
                                state  <= HALT;
                                halted <= 1'b1;
                            end else begin
                                state  <= REQ;
                            end
                        end
                    end
                    REQ: begin
                        // ROM samples rom_index at this edge.
                        state <= WAIT;
                    end
                    WAIT: begin
                        instr       <= rom_data;
                        instr_pc    <= pc;
                        instr_valid <= 1'b1;
                        pc          <= pc + PC_ONE;
                        state       <= HOLD;
                    end
                    HOLD: begin
                        // instr/instr_pc are untouched until decode takes them.
                        if (transfer) begin
                            instr_valid <= 1'b0;
                            if (pc_outside) begin
                                state  <= HALT;
                                halted <= 1'b1;
                            end else if (en) begin
                                state  <= REQ;
                            end else begin
                                state  <= IDLE;
                            end
                        end
                    end
                    HALT: begin
                        instr_valid <= 1'b0;
                        halted      <= 1'b1;
                    end
                    default: begin
                        state       <= IDLE;
                        instr_valid <= 1'b0;
                        halted      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a transaction-level
// model of the fetch pipeline.
module tb_fetch_sequencer;

    localparam int PC_W  = 32;
    localparam int DEPTH = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            en = 1'b0;
    logic [PC_W-1:0] rom_index;
    logic [31:0]     rom_data = '0;
    logic [31:0]     instr;
    logic [PC_W-1:0] instr_pc;
    logic            instr_valid;
    logic            instr_ready = 1'b0;
    logic            redirect_valid = 1'b0;
    logic [PC_W-1:0] redirect_pc = '0;
    logic            halted;
    logic [15:0]     fetch_cnt;

    int errors   = 0;
    int n_checks = 0;
    bit compare_on = 1'b0;

    logic [31:0] rom [DEPTH];

    fetch_sequencer #(.PC_W(PC_W), .ROM_DEPTH(DEPTH), .RESET_PC('0)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .rom_index(rom_index), .rom_data(rom_data),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halted(halted), .fetch_cnt(fetch_cnt)
    );

    always #5 clk = ~clk;

    // Synchronous ROM with one cycle of read latency.
    always @(posedge clk) begin
        rom_data <= (rom_index < DEPTH) ? rom[rom_index[3:0]] : 32'h0;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a fetch is "in flight" for two edges after it is issued, then the
    // word ROM[pc] is offered until taken. Redirects cancel anything in flight.
    logic [PC_W-1:0] m_pc    = '0;
    logic [31:0]     m_instr = '0;
    logic [PC_W-1:0] m_ipc   = '0;
    bit              m_valid = 0;
    bit              m_halt  = 0;
    int              m_cnt   = 0;
    int              m_left  = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc = '0; m_instr = '0; m_ipc = '0;
            m_valid = 0; m_halt = 0; m_cnt = 0; m_left = 0;
        end else begin
            if (m_valid && instr_ready) begin
                if (m_cnt < 65535) m_cnt++;
                $display("xfer pc=%0d instr=%08h cnt=%0d", m_ipc, m_instr, m_cnt);
            end
            if (redirect_valid) begin
                m_valid = 0;
                m_left  = 0;
                m_pc    = redirect_pc;
                m_halt  = (redirect_pc >= DEPTH);
                if (!m_halt && en) m_left = 2;
            end else if (m_halt) begin
                m_valid = 0;
            end else if (m_valid) begin
                if (instr_ready) begin
                    m_valid = 0;
                    if (m_pc >= DEPTH) m_halt = 1;
                    else if (en) m_left = 2;
                end
            end else if (m_left == 2) begin
                m_left = 1;
            end else if (m_left == 1) begin
                m_left  = 0;
                m_instr = rom[m_pc[3:0]];
                m_ipc   = m_pc;
                m_valid = 1;
                m_pc    = m_pc + 1;
            end else if (en) begin
                if (m_pc >= DEPTH) m_halt = 1;
                else m_left = 2;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (compare_on) begin
            chk("m_rom_index", rom_index, m_pc);
            chk("m_valid", instr_valid, m_valid);
            chk("m_halted", halted, m_halt);
            chk("m_fetch_cnt", fetch_cnt, m_cnt);
            chk("m_instr", instr, m_instr);
            chk("m_instr_pc", instr_pc, m_ipc);
        end
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Waits (bounded) for instr_valid (which=0) or halted (which=1).
    task automatic wait_sig(input string name, input int bound, input bit which);
        bit seen = 0;
        for (int i = 0; i < bound && !seen; i++) begin
            tick();
            seen = which ? halted : instr_valid;
        end
        chk({name, "_timeout"}, seen, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) rom[i] = 32'h1000_0000 + 32'(i) * 32'h0011_1111;
        rom[0] = 32'h00011020;
        rom[1] = 32'h00642822;
        rom[2] = 32'h8CC40001;
        rom[8] = 32'h08000000;

        #1 rst_n = 1'b0;
        #1;
        chk("rst_valid", instr_valid, 0);
        chk("rst_cnt", fetch_cnt, 0);
        chk("rst_halted", halted, 0);
        chk("rst_index", rom_index, 0);
        chk("rst_instr", instr, 0);
        tick(2);
        compare_on = 1'b1;

        // Test 1: first two fetches after reset.
        rst_n = 1'b1; en = 1'b1; instr_ready = 1'b1;
        tick(2);
        chk("t1_not_yet", instr_valid, 0);
        tick();
        chk("t1_valid0", instr_valid, 1);
        chk("t1_instr0", instr, 32'h00011020);
        chk("t1_pc0", instr_pc, 0);
        tick();
        chk("t1_cnt1", fetch_cnt, 1);
        tick(2);
        chk("t1_valid1", instr_valid, 1);
        chk("t1_instr1", instr, 32'h00642822);
        chk("t1_pc1", instr_pc, 1);
        tick();
        chk("t1_cnt2", fetch_cnt, 2);

        // Test 2: decode stalls for 5 cycles at pc 2.
        instr_ready = 1'b0;
        tick(2);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_valid", instr_valid, 1);
            chk("t2_instr", instr, 32'h8CC40001);
            chk("t2_pc", instr_pc, 2);
            chk("t2_index", rom_index, 3);
            chk("t2_cnt", fetch_cnt, 2);
        end
        instr_ready = 1'b1;
        tick();
        chk("t2_cnt3", fetch_cnt, 3);

        // Test 3: redirect to 8 while the pc-3 word is in WAIT.
        tick();
        redirect_valid = 1'b1; redirect_pc = 8; instr_ready = 1'b0;
        tick();
        redirect_valid = 1'b0;
        chk("t3_discard", instr_valid, 0);
        chk("t3_index", rom_index, 8);
        wait_sig("t3_wait", 6, 0);
        chk("t3_instr", instr, 32'h08000000);
        chk("t3_pc", instr_pc, 8);
        chk("t3_cnt", fetch_cnt, 3);

        // Test 6: asynchronous reset in HOLD, no clock edge needed.
        #2 rst_n = 1'b0;
        #1;
        chk("t6_valid", instr_valid, 0);
        chk("t6_cnt", fetch_cnt, 0);
        chk("t6_instr", instr, 0);
        chk("t6_index", rom_index, 0);
        tick(2);
        rst_n = 1'b1; en = 1'b1; instr_ready = 1'b1;
        wait_sig("t6_wait", 6, 0);
        chk("t6_instr0", instr, 32'h00011020);

        // Test 4: free-run to the end of the ROM, then redirect back to 0.
        wait_sig("t4_halt", 100, 1);
        chk("t4_cnt16", fetch_cnt, 16);
        chk("t4_valid", instr_valid, 0);
        tick(3);
        chk("t4_still_halt", halted, 1);
        chk("t4_still_nv", instr_valid, 0);
        redirect_valid = 1'b1; redirect_pc = 0;
        tick();
        redirect_valid = 1'b0;
        chk("t4_unhalt", halted, 0);
        wait_sig("t4_refetch", 6, 0);
        chk("t4_instr0", instr, 32'h00011020);
        chk("t4_pc0", instr_pc, 0);

        // Test 5: redirect outside the ROM halts at once.
        redirect_valid = 1'b1; redirect_pc = 20;
        tick();
        redirect_valid = 1'b0;
        chk("t5_halt", halted, 1);
        chk("t5_index", rom_index, 20);
        tick(2);
        chk("t5_no_fetch", instr_valid, 0);
        chk("t5_still_halt", halted, 1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            en             = ($urandom % 8) != 0;
            instr_ready    = ($urandom % 4) != 0;
            redirect_valid = ($urandom % 16) == 0;
            redirect_pc    = PC_W'($urandom_range(0, 22));
            tick();
        end
        redirect_valid = 1'b0;
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, n_checks);
        $finish;
    end

endmodule
